jedro_1_lsu_bus: RTL and testbench



---
 rtl/jedro_1_lsu_bus_pkg.sv | 31 +++
 rtl/jedro_1_lsu_align.sv | 57 +++++
 rtl/jedro_1_lsu_bus.sv | 183 ++++++++++++++++++
 tb/tb_jedro_1_lsu_bus.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jedro_1_lsu_bus_pkg.sv
// jedro_1_lsu_bus_pkg
// Shared definitions for the LSU data-bus master: access-size encodings,
// FSM state encoding, data width, and the alignment-check helper.
package jedro_1_lsu_bus_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } lsu_state_t;

  // True for accesses the bus cannot perform: half on an odd address,
  // word off a word boundary, or the reserved size code.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      LSU_SIZE_B: bad = 1'b0;
      LSU_SIZE_H: bad = off[0];
      LSU_SIZE_W: bad = (off != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/jedro_1_lsu_align.sv
// jedro_1_lsu_align
// Purely combinational byte-lane logic for the LSU bus master.
// Ports:
//   i_size   access size (B/H/W)
//   i_off    byte offset within the word (addr[1:0])
//   i_uns    zero-extend loads when set
//   i_wdata  LSB-aligned store data
//   i_rdata  raw read word from the bus
//   o_be     byte enables for the bus
//   o_wdata  lane-replicated store data
//   o_ldata  shifted and extended load result
module jedro_1_lsu_align
  import jedro_1_lsu_bus_pkg::*;
(
  input  logic [1:0]            i_size,
  input  logic [1:0]            i_off,
  input  logic                  i_uns,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [3:0]            o_be,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [DATA_WIDTH-1:0] o_ldata
);

  logic [DATA_WIDTH-1:0] w_shift;
  logic                  w_sign_b;
  logic                  w_sign_h;

  // Bring the addressed byte/half down to bit 0.
  assign w_shift  = i_rdata >> {i_off, 3'b000};
  assign w_sign_b = ~i_uns & w_shift[7];
  assign w_sign_h = ~i_uns & w_shift[15];

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_ldata = i_rdata;
    case (i_size)
      LSU_SIZE_B: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
        o_ldata = {{24{w_sign_b}}, w_shift[7:0]};
      end
      LSU_SIZE_H: begin
        o_be    = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_ldata = {{16{w_sign_h}}, w_shift[15:0]};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_ldata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/jedro_1_lsu_bus.sv
// jedro_1_lsu_bus
// Data-memory bus master behind jedro_1_lsu. Accepts one load/store at a
// time, drives a req/gnt/rvalid handshake, and returns extended load data.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_*                 request from the LSU (req_ready_o high in IDLE)
//   dmem_*                data bus (word-aligned address, byte enables)
//   wb_valid_o/rd/data    load writeback, one-cycle pulse
//   st_done_o             store completion pulse
//   err_misaligned_o      misaligned / reserved-size request pulse
//   err_bus_o             bus timeout pulse
module jedro_1_lsu_bus
  import jedro_1_lsu_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [4:0]            req_rd_i,
  output logic                  dmem_req_o,
  input  logic                  dmem_gnt_i,
  output logic                  dmem_we_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  wb_valid_o,
  output logic [4:0]            wb_rd_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic                  st_done_o,
  output logic                  err_misaligned_o,
  output logic                  err_bus_o
);

  localparam int CNT_W   = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam int TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  lsu_state_t r_state, w_state_next;

  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [1:0]            r_off;
  logic [31:2]           r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [4:0]            r_rd;
  logic [CNT_W-1:0]      r_cnt;

  logic                  r_wb_valid;
  logic [4:0]            r_wb_rd;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic                  r_st_done;
  logic                  r_err_mis;
  logic                  r_err_bus;

  logic                  w_misaligned;
  logic                  w_accept;
  logic                  w_resp;
  logic                  w_timeout;
  logic                  w_to_hit;
  logic                  w_in_req;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_ldata;

  assign w_misaligned = is_misaligned(req_size_i, req_addr_i[1:0]);
  // The counter is zero on the first REQ cycle, so hitting TO_LAST means
  // TIMEOUT_CYCLES cycles have been spent on the bus.
  assign w_to_hit     = (TIMEOUT_CYCLES != 0) && (r_cnt >= CNT_W'(TO_LAST));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_resp       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid_i && !w_misaligned) begin
          w_state_next = S_REQ;
          w_accept     = 1'b1;
        end
      end
      S_REQ: begin
        // Timeout takes priority over a late grant; any rvalid here is ignored.
        if (w_to_hit) begin
          w_state_next = S_IDLE;
          w_timeout    = 1'b1;
        end else if (dmem_gnt_i) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response arriving on the timeout cycle still completes normally.
        if (dmem_rvalid_i) begin
          w_state_next = S_IDLE;
          w_resp       = 1'b1;
        end else if (w_to_hit) begin
          w_state_next = S_IDLE;
          w_timeout    = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || r_state == S_IDLE) r_cnt <= '0;
    else                            r_cnt <= r_cnt + CNT_W'(1);
  end

  // Request fields: only meaningful while busy, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_we    <= req_we_i;
      r_size  <= req_size_i;
      r_uns   <= req_unsigned_i;
      r_off   <= req_addr_i[1:0];
      r_addr  <= req_addr_i[31:2];
      r_wdata <= req_wdata_i;
      r_rd    <= req_rd_i;
    end
  end

  jedro_1_lsu_align u_align (
    .i_size  (r_size),
    .i_off   (r_off),
    .i_uns   (r_uns),
    .i_wdata (r_wdata),
    .i_rdata (dmem_rdata_i),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_ldata (w_ldata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_st_done  <= 1'b0;
      r_err_mis  <= 1'b0;
      r_err_bus  <= 1'b0;
    end else begin
      r_wb_valid <= w_resp && !r_we;
      r_st_done  <= w_resp && r_we;
      r_err_mis  <= (r_state == S_IDLE) && req_valid_i && w_misaligned;
      r_err_bus  <= w_timeout;
      if (w_resp && !r_we) begin
        r_wb_rd   <= r_rd;
        r_wb_data <= w_ldata;
      end
    end
  end

  // Bus outputs are gated so they read zero outside REQ (and after reset).
  assign w_in_req         = (r_state == S_REQ);
  assign req_ready_o      = (r_state == S_IDLE);
  assign dmem_req_o       = w_in_req;
  assign dmem_we_o        = w_in_req & r_we;
  assign dmem_be_o        = w_in_req ? w_be : 4'b0000;
  assign dmem_addr_o      = w_in_req ? {r_addr, 2'b00} : '0;
  assign dmem_wdata_o     = w_in_req ? w_wdata : '0;
  assign wb_valid_o       = r_wb_valid;
  assign wb_rd_o          = r_wb_rd;
  assign wb_data_o        = r_wb_data;
  assign st_done_o        = r_st_done;
  assign err_misaligned_o = r_err_mis;
  assign err_bus_o        = r_err_bus;

endmodule

// File: tb/tb_jedro_1_lsu_bus.sv
// tb_jedro_1_lsu_bus
// Randomized plus directed bench for jedro_1_lsu_bus with a per-transaction
// reference model built from the access rules (byte counts, arithmetic
// replication and extension).
module tb_jedro_1_lsu_bus;

  localparam int TO = 6;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        dmem_req_o;
  logic        dmem_gnt_i;
  logic        dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        st_done_o;
  logic        err_misaligned_o;
  logic        err_bus_o;

  int total = 0;
  int bad   = 0;

  jedro_1_lsu_bus #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_we_i         (req_we_i),
    .req_size_i       (req_size_i),
    .req_unsigned_i   (req_unsigned_i),
    .req_addr_i       (req_addr_i),
    .req_wdata_i      (req_wdata_i),
    .req_rd_i         (req_rd_i),
    .dmem_req_o       (dmem_req_o),
    .dmem_gnt_i       (dmem_gnt_i),
    .dmem_we_o        (dmem_we_o),
    .dmem_be_o        (dmem_be_o),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .dmem_rvalid_i    (dmem_rvalid_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .wb_valid_o       (wb_valid_o),
    .wb_rd_o          (wb_rd_o),
    .wb_data_o        (wb_data_o),
    .st_done_o        (st_done_o),
    .err_misaligned_o (err_misaligned_o),
    .err_bus_o        (err_bus_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_misaligned(input logic [1:0] size, input logic [31:0] addr);
    int off = int'(addr % 4);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1) return (off % 2) != 0;
    if (size == 2'd2) return off != 0;
    return 1'b0;
  endfunction

  function automatic int m_nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    int n   = m_nbytes(size);
    int off = int'(addr % 4);
    int v   = ((1 << n) - 1) << off;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return (wd % 256) * 32'h0101_0101;
    if (size == 2'd1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input bit uns,
                                         input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    logic [31:0] span;
    int nbits = 8 * m_nbytes(size);
    if (nbits == 32) return rd;
    span = 32'd1 << nbits;
    v = (rd / (32'd1 << (8 * (addr % 4)))) % span;
    if (!uns && v >= span / 2) v = v - span;
    return v;
  endfunction

  // ---------------- one transaction ----------------
  // g: busy-cycle index at which the bench grants; r: extra WAIT cycles
  // before rvalid. noise drives a stray rvalid together with the grant.
  task automatic do_txn(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] rdata, input int g, input int r, input bit noise);
    int  resp_idx;
    int  last;
    bit  ok;
    @(negedge clk_i);
    chk("idle_ready", {31'b0, req_ready_o}, 32'd1);
    chk("idle_req", {31'b0, dmem_req_o}, 32'd0);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wd;
    req_rd_i       = rd;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    if (m_misaligned(size, addr)) begin
      chk("mis_pulse", {31'b0, err_misaligned_o}, 32'd1);
      chk("mis_noreq", {31'b0, dmem_req_o}, 32'd0);
      chk("mis_ready", {31'b0, req_ready_o}, 32'd1);
      @(negedge clk_i);
      chk("mis_once", {31'b0, err_misaligned_o}, 32'd0);
      chk("mis_noreq2", {31'b0, dmem_req_o}, 32'd0);
      return;
    end
    resp_idx = g + 1 + r;
    ok       = (resp_idx <= TO - 1);
    last     = ok ? resp_idx : TO - 1;
    for (int k = 0; k <= last; k++) begin
      chk("bus_req", {31'b0, dmem_req_o}, (k <= g) ? 32'd1 : 32'd0);
      if (k <= g) begin
        chk("bus_addr", dmem_addr_o, {addr[31:2], 2'b00});
        chk("bus_be", {28'b0, dmem_be_o}, {28'b0, m_be(size, addr)});
        chk("bus_we", {31'b0, dmem_we_o}, {31'b0, we});
        if (we) chk("bus_wdata", dmem_wdata_o, m_wdata(size, wd));
      end
      dmem_gnt_i    = (k == g);
      dmem_rvalid_i = (k == resp_idx) || (noise && k == g);
      dmem_rdata_i  = (k == resp_idx) ? rdata : $urandom;
      @(negedge clk_i);
    end
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    chk("wb_valid", {31'b0, wb_valid_o}, {31'b0, ok && !we});
    chk("st_done", {31'b0, st_done_o}, {31'b0, ok && we});
    chk("err_bus", {31'b0, err_bus_o}, {31'b0, !ok});
    chk("end_ready", {31'b0, req_ready_o}, 32'd1);
    chk("end_noreq", {31'b0, dmem_req_o}, 32'd0);
    if (ok && !we) begin
      chk("wb_data", wb_data_o, m_load(size, uns, addr, rdata));
      chk("wb_rd", {27'b0, wb_rd_o}, {27'b0, rd});
    end
    if (!ok) begin
      // A response after the timeout must be ignored.
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = $urandom;
      @(negedge clk_i);
      dmem_rvalid_i = 1'b0;
      chk("late_wb", {31'b0, wb_valid_o}, 32'd0);
      chk("late_st", {31'b0, st_done_o}, 32'd0);
      chk("late_err", {31'b0, err_bus_o}, 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {31'b0, req_ready_o}, 32'd1);
    chk({tag, "_ctl"}, {26'b0, dmem_req_o, dmem_we_o, wb_valid_o, st_done_o,
                        err_misaligned_o, err_bus_o}, 32'd0);
    chk({tag, "_be"}, {28'b0, dmem_be_o}, 32'd0);
    chk({tag, "_addr"}, dmem_addr_o, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata_o, 32'd0);
    chk({tag, "_wbdata"}, wb_data_o, 32'd0);
    chk({tag, "_wbrd"}, {27'b0, wb_rd_o}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i          = 1'b1;
    req_valid_i    = 1'b0;
    req_we_i       = 1'b0;
    req_size_i     = 2'd0;
    req_unsigned_i = 1'b0;
    req_addr_i     = '0;
    req_wdata_i    = '0;
    req_rd_i       = '0;
    dmem_gnt_i     = 1'b0;
    dmem_rvalid_i  = 1'b0;
    dmem_rdata_i   = '0;
    repeat (2) @(negedge clk_i);
    chk_all_zero("reset");
    rst_i = 1'b0;

    // LB 0x103, zero wait states
    do_txn(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 5'd7, 32'h80AA_BBCC, 0, 0, 1'b0);
    chk("lb_const", wb_data_o, 32'hFFFF_FF80);
    // LHU 0x202
    do_txn(1'b0, 2'd1, 1'b1, 32'h0000_0202, 32'h0, 5'd9, 32'h8001_0000, 0, 1, 1'b0);
    chk("lhu_const", wb_data_o, 32'h0000_8001);
    // SB 0x301, grant delayed 3 cycles
    do_txn(1'b1, 2'd0, 1'b0, 32'h0000_0301, 32'h1234_56AB, 5'd0, 32'h0, 3, 0, 1'b0);
    // LW 0x402 misaligned
    do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0402, 32'h0, 5'd3, 32'h0, 0, 0, 1'b0);
    // Reserved size
    do_txn(1'b1, 2'd3, 1'b0, 32'h0000_0400, 32'h0, 5'd3, 32'h0, 0, 0, 1'b0);
    // Timeout with no grant, and timeout in WAIT
    do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0, 5'd4, 32'h0, TO, 0, 1'b0);
    do_txn(1'b1, 2'd2, 1'b0, 32'h0000_0504, 32'hDEAD_BEEF, 5'd4, 32'h0, 0, TO, 1'b0);
    // rvalid on the last allowed cycle wins over the timeout
    do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0508, 32'h0, 5'd5, 32'hCAFE_F00D, 1, TO - 3, 1'b0);
    // Stray rvalid alongside grant in REQ is ignored
    do_txn(1'b0, 2'd0, 1'b1, 32'h0000_0601, 32'h0, 5'd6, 32'h0000_F100, 1, 0, 1'b1);

    // Reset while in WAIT, with a response arriving during reset
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2; req_unsigned_i = 1'b0;
    req_addr_i = 32'h0000_0700; req_rd_i = 5'd11;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    dmem_gnt_i  = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    chk("rst_inwait", {31'b0, dmem_req_o}, 32'd0);
    rst_i = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h5555_AAAA;
    @(negedge clk_i);
    rst_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    chk_all_zero("midrst");
    @(negedge clk_i);
    chk("midrst_nowb", {31'b0, wb_valid_o}, 32'd0);
    do_txn(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0, 5'd12, 32'h1357_9BDF, 0, 0, 1'b0);
    chk("lw_after_rst", wb_data_o, 32'h1357_9BDF);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      do_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
             $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
